batch_spi_sender: RTL and testbench

Downstream stage of the colour batch buffer. It accepts a completed colour batch (BATCH_SIZE bytes), double-buffers it, and shifts it out over a mode-0 SPI link to a CH32V003 matrix controller. It owns CS framing (one CS-low window per batch), SCLK generation by clock division, and overflow signalling when batches arrive faster than the link can drain them.

---
 rtl/batch_spi_sender.sv | 149 ++++++++++++++
 tb/tb_batch_spi_sender.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/batch_spi_sender.sv
// rtl/batch_spi_sender.sv - double-buffered colour batch sender over a mode-0 SPI link
// Define BATCH_SPI_START_BYTE_EN to prefix every frame with START_BYTE.
module batch_spi_sender #(
  parameter int         BATCH_SIZE = 8,
  parameter int         CLK_DIV    = 2,
  parameter int         CS_GAP     = 2,
  parameter logic [7:0] START_BYTE = 8'hA5
) (
  input  logic                    I_rgb_clk,
  input  logic                    I_rst_n,
  input  logic                    I_batch_ready,
  input  logic [8*BATCH_SIZE-1:0] I_batch_color,
  output logic                    O_spi_sclk,
  output logic                    O_spi_mosi,
  output logic                    O_spi_cs_n,
  output logic                    O_busy,
  output logic                    O_overflow
);

`ifdef BATCH_SPI_START_BYTE_EN
  localparam int HDR = 8;
`else
  localparam int HDR = 0 * $bits(START_BYTE);
`endif
  localparam int N  = 8 * BATCH_SIZE + HDR;
  localparam int BW = $clog2(N + 8);
  localparam int DW = $clog2(CLK_DIV + CS_GAP);

  localparam logic [BW-1:0] LAST_BIT   = BW'(N - 1);
  localparam logic [DW-1:0] DIV_RELOAD = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_RELOAD = DW'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_t;

  state_t                  state;
  logic                    pending_valid;
  logic [8*BATCH_SIZE-1:0] pending_data;
  logic [N-1:0]            shifter;
  logic [N-1:0]            load_word;
  logic [BW-1:0]           bit_cnt;
  logic [DW-1:0]           div_cnt;
  logic                    sclk_q;
  logic                    mosi_q;
  logic                    cs_n_q;
  logic                    overflow_q;
  logic                    take;

  // Byte 0 ends up in the top bits so the shifter always sends its MSB next.
  always_comb begin
    load_word = '0;
`ifdef BATCH_SPI_START_BYTE_EN
    load_word[N-1 -: 8] = START_BYTE;
`endif
    for (int i = 0; i < BATCH_SIZE; i++)
      load_word[N-1-HDR-8*i -: 8] = pending_data[8*i +: 8];
  end

  // Pending moves to the shifter from IDLE, or straight out of the last GAP cycle.
  assign take = pending_valid && ((state == IDLE) || (state == GAP && div_cnt == '0));

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state         <= IDLE;
      pending_valid <= 1'b0;
      pending_data  <= '0;
      shifter       <= '0;
      bit_cnt       <= '0;
      div_cnt       <= '0;
      sclk_q        <= 1'b0;
      mosi_q        <= 1'b0;
      cs_n_q        <= 1'b1;
      overflow_q    <= 1'b0;
    end else begin
      if (I_batch_ready) begin
        if (!pending_valid || take) begin
          pending_data  <= I_batch_color;
          pending_valid <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (take) begin
        pending_valid <= 1'b0;
      end

      if (take) begin
        state   <= CS_SETUP;
        shifter <= load_word;
        mosi_q  <= load_word[N-1];
        cs_n_q  <= 1'b0;
        sclk_q  <= 1'b0;
        div_cnt <= DIV_RELOAD;
      end else begin
        case (state)
          IDLE: ;
          CS_SETUP: begin
            if (div_cnt == '0) begin
              state   <= SHIFT;
              sclk_q  <= 1'b1;
              bit_cnt <= '0;
              div_cnt <= DIV_RELOAD;
            end else begin
              div_cnt <= div_cnt - 1'b1;
            end
          end
          SHIFT: begin
            if (div_cnt != '0) begin
              div_cnt <= div_cnt - 1'b1;
            end else begin
              div_cnt <= DIV_RELOAD;
              if (!sclk_q) begin
                sclk_q <= 1'b1;
              end else if (bit_cnt == LAST_BIT) begin
                sclk_q <= 1'b0;
                state  <= CS_HOLD;
              end else begin
                sclk_q  <= 1'b0;
                shifter <= {shifter[N-2:0], shifter[N-1]};
                mosi_q  <= shifter[N-2];
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          CS_HOLD: begin
            if (div_cnt == '0) begin
              state   <= GAP;
              cs_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
              div_cnt <= GAP_RELOAD;
            end else begin
              div_cnt <= div_cnt - 1'b1;
            end
          end
          GAP: begin
            if (div_cnt == '0) state <= IDLE;
            else               div_cnt <= div_cnt - 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign O_spi_sclk = sclk_q;
  assign O_spi_mosi = mosi_q;
  assign O_spi_cs_n = cs_n_q;
  assign O_overflow = overflow_q;
  assign O_busy     = pending_valid | (state != IDLE);

endmodule

// File: tb/tb_batch_spi_sender.sv
// tb/tb_batch_spi_sender.sv - randomized, model-checked bench for batch_spi_sender
// Honours BATCH_SPI_START_BYTE_EN when the design is built with it.
module tb_batch_spi_sender;
  localparam int BS = 8;
  localparam int D  = 2;
  localparam int G  = 2;
`ifdef BATCH_SPI_START_BYTE_EN
  localparam int HDR = 8;
  localparam int EXP_LOW = 290, EXP_RISE = 72, EXP_LOW2 = 33, EXP_RISE2 = 16;
  localparam logic [15:0] PAT2 = 16'hA581;
`else
  localparam int HDR = 0;
  localparam int EXP_LOW = 258, EXP_RISE = 64, EXP_LOW2 = 17, EXP_RISE2 = 8;
  localparam logic [15:0] PAT2 = 16'h0081;
`endif
  localparam int N = 8 * BS + HDR;
  localparam int L = D * (2 * N + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ready = 1'b0;
  logic [8*BS-1:0] color = '0;
  logic sclk, mosi, cs_n, busy, ovf;
  logic ready2 = 1'b0;
  logic [7:0] color2 = '0;
  logic sclk2, mosi2, cs_n2, busy2, ovf2;

  always #5 clk = ~clk;

  batch_spi_sender #(.BATCH_SIZE(BS), .CLK_DIV(D), .CS_GAP(G), .START_BYTE(8'hA5)) dut (
    .I_rgb_clk(clk), .I_rst_n(rst_n), .I_batch_ready(ready), .I_batch_color(color),
    .O_spi_sclk(sclk), .O_spi_mosi(mosi), .O_spi_cs_n(cs_n), .O_busy(busy), .O_overflow(ovf));

  batch_spi_sender #(.BATCH_SIZE(1), .CLK_DIV(1), .CS_GAP(2), .START_BYTE(8'hA5)) dut2 (
    .I_rgb_clk(clk), .I_rst_n(rst_n), .I_batch_ready(ready2), .I_batch_color(color2),
    .O_spi_sclk(sclk2), .O_spi_mosi(mosi2), .O_spi_cs_n(cs_n2), .O_busy(busy2), .O_overflow(ovf2));

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: frame k starts at the first edge where a batch is pending and the
  // link is free; frames are L cycles of CS low followed by G cycles of CS high.
  bit m_pv = 0, m_ovf = 0, m_have = 0;
  logic [8*BS-1:0] m_pd = '0;
  int m_fs = 0, m_free = 0;
  bit m_q[$];
  logic [7:0] hdr_byte = 8'hA5;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_pv = 0; m_ovf = 0; m_have = 0; m_free = 0;
    end else begin
      if (m_pv && cyc >= m_free) begin
        m_q.delete();
        if (HDR != 0) for (int k = 7; k >= 0; k--) m_q.push_back(hdr_byte[k]);
        for (int b = 0; b < BS; b++)
          for (int k = 7; k >= 0; k--) m_q.push_back(m_pd[8*b+k]);
        m_fs = cyc; m_free = cyc + L + G; m_have = 1; m_pv = 0;
      end
      if (ready) begin
        if (!m_pv) begin m_pd = color; m_pv = 1; end
        else m_ovf = 1;
      end
    end
  end

  bit chk_en = 0;
  int c_k, c_ph;
  bit e_cs, e_sclk, e_mosi, e_busy, c_in, c_mchk;

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        check("rst_cs_n", cs_n, 1); check("rst_sclk", sclk, 0); check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0); check("rst_overflow", ovf, 0);
      end else begin
        c_k = cyc - m_fs;
        c_in = m_have && c_k < L;
        e_cs = !c_in; e_sclk = 0; e_mosi = 0; c_mchk = 1;
        if (c_in) begin
          if (c_k < D) e_mosi = m_q[0];
          else begin
            c_ph = (c_k - D) / D;
            if (c_ph < 2 * N - 1) begin
              e_sclk = (c_ph % 2 == 0);
              e_mosi = m_q[(c_ph + 1) / 2];
            end else c_mchk = 0;
          end
        end
        e_busy = m_pv || (m_have && c_k < L + G);
        check("model_cs_n", cs_n, e_cs);
        check("model_sclk", sclk, e_sclk);
        if (c_mchk) check("model_mosi", mosi, e_mosi);
        check("model_busy", busy, e_busy);
        check("model_overflow", ovf, m_ovf);
      end
    end
  end

  // Wire-level frame monitor for the literal checks.
  bit p_sclk = 0, p_cs = 1, p_busy = 0;
  int cur_rise = 0, cur_low = 0, high_cnt = 0;
  bit cur_bits[$], last_bits[$];
  int last_rise = 0, last_low = 0, last_gap = 0, frames_done = 0;
  int fall_cyc = 0, rise_cyc = 0, busy_fall_cyc = 0;

  always @(negedge clk) begin
    if (!cs_n) begin
      if (p_cs) begin last_gap = high_cnt; fall_cyc = cyc; end
      cur_low++;
      if (sclk && !p_sclk) begin cur_rise++; cur_bits.push_back(mosi); end
    end else begin
      if (!p_cs) begin
        last_rise = cur_rise; last_low = cur_low; last_bits = cur_bits;
        cur_bits.delete(); cur_rise = 0; cur_low = 0; high_cnt = 0;
        frames_done++; rise_cyc = cyc;
      end
      high_cnt++;
    end
    if (p_busy && !busy) busy_fall_cyc = cyc;
    p_sclk = sclk; p_cs = cs_n; p_busy = busy;
  end

  int m2_low = 0, m2_rise = 0, m2_prev = 0, m2_min = 999, m2_max = 0, m2_done = 0;
  bit p2_sclk = 0, p2_cs = 1;
  bit m2_bits[$];

  always @(negedge clk) begin
    if (!cs_n2) begin
      m2_low++;
      if (sclk2 && !p2_sclk) begin
        if (m2_rise > 0) begin
          if (cyc - m2_prev < m2_min) m2_min = cyc - m2_prev;
          if (cyc - m2_prev > m2_max) m2_max = cyc - m2_prev;
        end
        m2_prev = cyc; m2_rise++; m2_bits.push_back(mosi2);
      end
    end else if (!p2_cs) m2_done++;
    p2_sclk = sclk2; p2_cs = cs_n2;
  end

  function automatic logic [7:0] lbyte(input int j);
    logic [7:0] r = '0;
    for (int k = 0; k < 8; k++) r = {r[6:0], last_bits[8*j+k]};
    return r;
  endfunction

  task automatic strobe(input logic [63:0] d, output int s);
    ready = 1'b1; color = d;
    @(negedge clk);
    ready = 1'b0; s = cyc;
  endtask

  task automatic strobe_at(input int edge_no, input logic [63:0] d);
    int g = 0, s;
    while (cyc < edge_no - 1 && g < 5000) begin @(negedge clk); g++; end
    strobe(d, s);
    check("strobe_edge", s, edge_no);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin @(negedge clk); n++; end
    check("frames_reached", frames_done >= target, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    @(negedge clk);
    check("idle_reached", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish within 50000 cycles");
    $fatal(1);
  end

  int s, f0, n;
  logic [63:0] a, b, c;

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    check("reset_cs_n", cs_n, 1); check("reset_sclk", sclk, 0); check("reset_mosi", mosi, 0);
    check("reset_busy", busy, 0); check("reset_overflow", ovf, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single known batch.
    f0 = frames_done;
    strobe(64'h0807060504030201, s);
    wait_frames(f0 + 1, L + 100);
    check("single_cs_fall_edges", fall_cyc - s + 1, 2);
    check("single_rises", last_rise, EXP_RISE);
    check("single_cs_low", last_low, EXP_LOW);
`ifdef BATCH_SPI_START_BYTE_EN
    check("single_header", lbyte(0), 8'hA5);
`endif
    for (int j = 0; j < 8; j++) check("single_byte", lbyte(HDR / 8 + j), j + 1);
    wait_idle(100);

    // Strobe lands on the edge that moves pending into the shifter.
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    f0 = frames_done;
    strobe(a, s);
    repeat (5) @(negedge clk);
    strobe(b, n);
    strobe_at(s + 1 + L + G, c);
    @(negedge clk);
    check("take_edge_overflow", ovf, 0);
    wait_frames(f0 + 3, 3 * (L + G) + 100);
    check("take_edge_frame3_start", fall_cyc, s + 1 + 2 * (L + G));
    check("take_edge_rises", last_rise, EXP_RISE);
    for (int j = 0; j < 8; j++) check("take_edge_byte", lbyte(HDR / 8 + j), c[8*j +: 8]);
    check("take_edge_overflow_end", ovf, 0);
    wait_idle(100);

    // Three batches eight cycles apart: third one is dropped.
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    f0 = frames_done;
    strobe(a, s);
    strobe_at(s + 8, b);
    strobe_at(s + 16, c);
    @(negedge clk);
    check("burst_overflow", ovf, 1);
    wait_frames(f0 + 2, 2 * (L + G) + 100);
    check("burst_gap", last_gap, G);
    for (int j = 0; j < 8; j++) check("burst_byte2", lbyte(HDR / 8 + j), b[8*j +: 8]);
    wait_idle(100);
    check("burst_busy_fall", busy_fall_cyc - rise_cyc, G);
    repeat (300) @(negedge clk);
    check("burst_no_third_frame", frames_done, f0 + 2);
    check("burst_overflow_sticky", ovf, 1);
    do_reset();
    check("reset_clears_overflow", ovf, 0);

    // Random traffic, bursts and occasional resets, checked every cycle by the model.
    repeat (30) begin
      repeat ($urandom_range(1, 350)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) do_reset();
      strobe({$urandom, $urandom}, s);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        strobe({$urandom, $urandom}, s);
      end
    end
    wait_idle(3 * (L + G) + 100);
    do_reset();

    // Reset in the middle of a frame.
    strobe({$urandom, $urandom}, s);
    n = 0;
    while (cur_rise < 20 && n < L) begin @(negedge clk); n++; end
    check("midreset_reached_bit20", cur_rise >= 20, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_cs_n", cs_n, 1); check("midreset_sclk", sclk, 0); check("midreset_busy", busy, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    a = {$urandom, $urandom};
    f0 = frames_done;
    strobe(a, s);
    wait_frames(f0 + 1, L + 100);
    check("midreset_cs_low", last_low, EXP_LOW);
    check("midreset_rises", last_rise, EXP_RISE);
    for (int j = 0; j < 8; j++) check("midreset_byte", lbyte(HDR / 8 + j), a[8*j +: 8]);
    wait_idle(100);

    // Fastest configuration on the second instance.
    ready2 = 1'b1; color2 = 8'h81;
    @(negedge clk);
    ready2 = 1'b0;
    n = 0;
    while (m2_done < 1 && n < 200) begin @(negedge clk); n++; end
    check("div1_frame_done", m2_done, 1);
    check("div1_cs_low", m2_low, EXP_LOW2);
    check("div1_rises", m2_rise, EXP_RISE2);
    check("div1_period_min", m2_min, 2);
    check("div1_period_max", m2_max, 2);
    for (int i = 0; i < EXP_RISE2; i++) check("div1_bit", m2_bits[i], PAT2[EXP_RISE2-1-i]);
    repeat (5) @(negedge clk);
    check("div1_busy_end", busy2, 0);
    check("div1_overflow", ovf2, 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
